// File: rtl/sd_spi_card_responder_pkg.sv
// sd_spi_pkg: shared constants, R1 bit positions and FSM state type for the SD SPI card responder.
package sd_spi_pkg;
    localparam logic [5:0] CMD0 = 6'd0;
    localparam logic [5:0] CMD8 = 6'd8;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam int R1_IDLE = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC = 3;
    localparam int FRAME_LEN = 48;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    typedef enum logic [1:0] {S_WAIT, S_RX, S_NCR, S_TX} state_e;
endpackage

// File: rtl/sd_spi_card_responder_if.sv
// sd_spi_card_responder_if: SD SPI bus plus decoded-command status seen by the host side.
interface sd_spi_card_responder_if;
    logic sd_cs;
    logic sd_mosi;
    logic sd_miso;
    logic cmd_valid;
    logic [5:0] cmd_index;
    logic [31:0] cmd_arg;
    logic card_idle;
    logic card_ready;
    logic crc_err;
    modport master (output sd_cs, sd_mosi, input sd_miso, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready, crc_err);
    modport slave (input sd_cs, sd_mosi, output sd_miso, cmd_valid, cmd_index, cmd_arg, card_idle, card_ready, crc_err);
endinterface

// File: rtl/sd_spi_card_responder_crc7.sv
// sd_crc7_serial: bit-serial CRC7 (x^7+x^3+1), cleared on the command start bit.
module sd_crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       div_clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;
    always_comb crc_d = clr ? 7'h00 : en ? ({crc_q[5:0], 1'b0} ^ ((din ^ crc_q[6]) ? CRC7_POLY : 7'h00)) : crc_q;
    always_ff @(posedge div_clk or negedge rst_n)
        if (!rst_n) crc_q <= 7'h00;
        else crc_q <= crc_d;
    assign crc = crc_q;
endmodule

// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card model answering CMD0/CMD8/CMD55/ACMD41.
// Define SD_RESP_CRC_CHK_EN to check the CRC7 of every received frame.
module sd_spi_card_responder
    import sd_spi_pkg::*;
#(
    parameter int          NCR_CYCLES      = 2,
    parameter int          ACMD41_BUSY_CNT = 3,
    parameter logic [31:0] OCR_VALUE       = 32'h80FF8000
) (
    input  logic div_clk,
    input  logic rst_n,
    sd_spi_card_responder_if.slave bus
);
    localparam logic [5:0] NCR_LAST = 6'(NCR_CYCLES - 1);
    localparam logic [5:0] RX_LAST = 6'(FRAME_LEN - 1);
    localparam logic [5:0] TX_END = 6'(FRAME_LEN);
    localparam logic [7:0] BUSY_INIT = 8'(ACMD41_BUSY_CNT);

    state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [45:0] sr_q, sr_d;
    logic [47:0] tx_q, tx_d;
    logic [31:0] arg_q, arg_d, pay;
    logic [7:0] busy_q, busy_d, r1;
    logic miso_q, miso_d, valid_q, valid_d, idle_q, idle_d, ready_q, ready_d;
    logic app_q, app_d, pwr_q, pwr_d, crc_err_q, crc_err_d;
    logic start, last, accept, tx_shift, crc_ok;

    // sr_q holds frame bits 46..1 at the decode edge; bit 0 is still on sd_mosi.
    assign start = state_q == S_WAIT && !bus.sd_cs && !bus.sd_mosi;
    assign last = state_q == S_RX && cnt_q == RX_LAST;
    assign accept = last && !bus.sd_cs && bus.sd_mosi && sr_q[45] && (pwr_q || sr_q[44:39] == CMD0);
    assign tx_shift = !bus.sd_cs && ((state_q == S_NCR && cnt_q == NCR_LAST) || (state_q == S_TX && cnt_q != TX_END));

`ifdef SD_RESP_CRC_CHK_EN
    logic [6:0] crc7;
    sd_crc7_serial u_crc (
        .div_clk(div_clk),
        .rst_n(rst_n),
        .clr(start),
        .en(state_q == S_RX && cnt_q <= 6'd39),
        .din(bus.sd_mosi),
        .crc(crc7)
    );
    assign crc_ok = crc7 == sr_q[6:0];
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge div_clk or negedge rst_n)
        if (!rst_n) state_q <= S_WAIT;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (bus.sd_cs) state_d = S_WAIT;
        else
            case (state_q)
                S_WAIT: state_d = bus.sd_mosi ? S_WAIT : S_RX;
                S_RX: state_d = !last ? S_RX : accept ? S_NCR : S_WAIT;
                S_NCR: state_d = cnt_q == NCR_LAST ? S_TX : S_NCR;
                S_TX: state_d = cnt_q == TX_END ? S_WAIT : S_TX;
            endcase
    end

    always_comb begin
        cnt_d = (start || (state_q == S_NCR && cnt_q == NCR_LAST)) ? 6'd1 : accept ? 6'd0 : cnt_q + 6'd1;
        sr_d = {sr_q[44:0], bus.sd_mosi};
        miso_d = tx_shift ? tx_q[47] : 1'b1;
        tx_d = tx_shift ? {tx_q[46:0], 1'b1} : tx_q;
        valid_d = accept;
        idx_d = idx_q;
        arg_d = arg_q;
        busy_d = busy_q;
        idle_d = idle_q;
        ready_d = ready_q;
        app_d = app_q;
        pwr_d = pwr_q;
        crc_err_d = crc_err_q;
        r1 = 8'h00;
        pay = 32'h0;
        if (accept) begin
            idx_d = sr_q[44:39];
            arg_d = sr_q[38:7];
            if (sr_q[44:39] == CMD0) begin
                pwr_d = 1'b1;
                idle_d = 1'b1;
                ready_d = 1'b0;
                app_d = 1'b0;
                busy_d = BUSY_INIT;
                crc_err_d = 1'b0;
            end else if (sr_q[44:39] == CMD8) pay = {20'h0, sr_q[18:7]};
            else if (sr_q[44:39] == CMD55) app_d = 1'b1;
            else if (sr_q[44:39] == ACMD41 && app_q) begin
                app_d = 1'b0;
                pay = OCR_VALUE;
                busy_d = busy_q != 8'd0 ? busy_q - 8'd1 : busy_q;
                idle_d = busy_q != 8'd0;
                ready_d = ready_q || busy_q == 8'd0;
            end else begin
                app_d = 1'b0;
                r1[R1_ILLEGAL] = 1'b1;
            end
            r1[R1_IDLE] = idle_d;
            // A corrupted command is still answered but must not change card state.
            if (!crc_ok) begin
                r1[R1_CRC] = 1'b1;
                crc_err_d = 1'b1;
                busy_d = busy_q;
                idle_d = idle_q;
                ready_d = ready_q;
                app_d = app_q;
                pwr_d = pwr_q;
            end
            tx_d = {r1, pay, 8'hFF};
        end
    end

    always_ff @(posedge div_clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q <= 6'd0;
            sr_q <= '0;
            tx_q <= '1;
            miso_q <= 1'b1;
            valid_q <= 1'b0;
            idx_q <= 6'd0;
            arg_q <= 32'h0;
            busy_q <= BUSY_INIT;
            idle_q <= 1'b0;
            ready_q <= 1'b0;
            app_q <= 1'b0;
            pwr_q <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q <= sr_d;
            tx_q <= tx_d;
            miso_q <= miso_d;
            valid_q <= valid_d;
            idx_q <= idx_d;
            arg_q <= arg_d;
            busy_q <= busy_d;
            idle_q <= idle_d;
            ready_q <= ready_d;
            app_q <= app_d;
            pwr_q <= pwr_d;
            crc_err_q <= crc_err_d;
        end

    assign bus.sd_miso = miso_q;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_index = idx_q;
    assign bus.cmd_arg = arg_q;
    assign bus.card_idle = idle_q;
    assign bus.card_ready = ready_q;
    assign bus.crc_err = crc_err_q;
endmodule
